// File: rtl/inst_rom_ldr_pkg.sv
// Shared constants and helpers for the instruction ROM with byte-stream loader.
package inst_rom_ldr_pkg;

   typedef logic [31:0] inst_word_t;

   localparam inst_word_t ZERO_WORD = 32'h0000_0000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Big-endian placement: lane 0 lands in bits 31:24.
   function automatic inst_word_t place_byte(input logic [7:0] b, input logic [1:0] lane);
      place_byte = {b, 24'h00_0000} >> {lane, 3'b000};
   endfunction

endpackage

// File: rtl/inst_rom_ldr_byte_packer.sv
// Gathers stream bytes into 32-bit words; a flush emits a partial word zero-padded in its low bytes.
module inst_rom_ldr_byte_packer
   import inst_rom_ldr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   input  logic        flush_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0] lane_q, lane_d;
   inst_word_t buf_q, buf_d;
   inst_word_t merged;
   logic       has_data;

   always_comb begin
      merged = buf_q;
      if (byte_valid_i) begin
         merged = buf_q | place_byte(byte_i, lane_q);
      end
      // A byte arriving with the flush is merged before the flush decision.
      has_data     = byte_valid_i || (lane_q != 2'd0);
      word_o       = merged;
      word_valid_o = (byte_valid_i && (lane_q == 2'd3)) || (flush_i && has_data);
      lane_d       = lane_q;
      buf_d        = buf_q;
      if (word_valid_o) begin
         lane_d = 2'd0;
         buf_d  = ZERO_WORD;
      end else if (byte_valid_i) begin
         lane_d = lane_q + 2'd1;
         buf_d  = merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         lane_q <= 2'd0;
         buf_q  <= ZERO_WORD;
      end else begin
         lane_q <= lane_d;
         buf_q  <= buf_d;
      end
   end

endmodule

// File: rtl/inst_rom_ldr.sv
// Zero-wait-state instruction memory for the fetch port, fillable at run time from a byte stream.
module inst_rom_ldr
   import inst_rom_ldr_pkg::*;
#(
   parameter int MEM_LOG2 = 17
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce_i,
   input  logic [31:0]         addr_i,
   output logic [31:0]         inst_o,
   input  logic                load_start_i,
   input  logic                byte_valid_i,
   input  logic [7:0]          byte_i,
   input  logic                load_end_i,
   output logic                load_busy_o,
   output logic                load_done_o,
   output logic                load_ovf_o,
   output logic [MEM_LOG2:0]   word_count_o
);

   localparam int                DEPTH    = 1 << MEM_LOG2;
   localparam logic [MEM_LOG2:0] FULL_CNT = {1'b1, {MEM_LOG2{1'b0}}};
   localparam logic [MEM_LOG2:0] CNT_ONE  = {{MEM_LOG2{1'b0}}, 1'b1};

   logic [1:0]          state_q, state_d;
   logic [MEM_LOG2:0]   count_q, count_d;
   logic                ovf_q, ovf_d;
   inst_word_t          mem_q [DEPTH];

   logic       in_load, full, byte_take, flush, ovf_hit;
   inst_word_t pack_word;
   logic       pack_valid;
   logic       unused_addr;

   assign in_load   = (state_q == ST_LOAD);
   assign full      = (count_q == FULL_CNT);
   // A start pulse pre-empts any byte or end arriving in the same cycle.
   assign byte_take = in_load && !load_start_i && byte_valid_i && !full;
   assign ovf_hit   = in_load && !load_start_i && byte_valid_i && full;
   assign flush     = in_load && !load_start_i && load_end_i;

   inst_rom_ldr_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (load_start_i),
      .byte_valid_i (byte_take),
      .byte_i       (byte_i),
      .flush_i      (flush),
      .word_o       (pack_word),
      .word_valid_o (pack_valid)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (load_start_i) begin
               state_d = ST_LOAD;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (load_start_i) begin
               count_d = '0;
               ovf_d   = 1'b0;
            end else begin
               if (ovf_hit)    ovf_d   = 1'b1;
               if (pack_valid) count_d = count_q + CNT_ONE;
               if (load_end_i) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (load_start_i) begin
               state_d = ST_LOAD;
               count_d = '0;
               ovf_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // The array has no reset so a loaded program survives a core reset.
   always_ff @(posedge clk) begin
      if (!rst && pack_valid && !full) begin
         mem_q[count_q[MEM_LOG2-1:0]] <= pack_word;
      end
   end

   assign unused_addr  = ^{addr_i[31:MEM_LOG2+2], addr_i[1:0]};
   assign inst_o       = (ce_i && !load_busy_o) ? mem_q[addr_i[MEM_LOG2+1:2]] : ZERO_WORD;
   assign load_busy_o  = in_load;
   assign load_done_o  = (state_q == ST_DONE);
   assign load_ovf_o   = ovf_q;
   assign word_count_o = count_q;

endmodule

// File: tb/tb_inst_rom_ldr.sv
// Randomized scoreboard bench for inst_rom_ldr using a small-depth instance.
module tb_inst_rom_ldr;

   localparam int ML    = 3;
   localparam int DEPTH = 1 << ML;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] inst_o;
   logic        load_start_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_i = '0;
   logic        load_end_i = 1'b0;
   logic        load_busy_o, load_done_o, load_ovf_o;
   logic [ML:0] word_count_o;

   always #5 clk = ~clk;

   inst_rom_ldr #(.MEM_LOG2(ML)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce_i         (ce_i),
      .addr_i       (addr_i),
      .inst_o       (inst_o),
      .load_start_i (load_start_i),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .load_end_i   (load_end_i),
      .load_busy_o  (load_busy_o),
      .load_done_o  (load_done_o),
      .load_ovf_o   (load_ovf_o),
      .word_count_o (word_count_o)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   logic [31:0] done_cnt_q[$];
   logic        done_ovf_q[$];
   logic [31:0] model_mem [DEPTH];
   logic        prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a stream of n bytes fills ceil(n/4) (or floor when no end) words, capped at DEPTH.
   task automatic model_stream(input logic [7:0] bq[$], input bit flushed,
                               output int cnt, output bit ovf);
      int n, used, nw;
      logic [31:0] w;
      n    = bq.size();
      used = (n > 4 * DEPTH) ? 4 * DEPTH : n;
      nw   = flushed ? (used + 3) / 4 : used / 4;
      for (int k = 0; k < nw; k++) begin
         w = '0;
         for (int b = 0; b < 4; b++) begin
            w = {w[23:0], (4 * k + b < used) ? bq[4 * k + b] : 8'h00};
         end
         model_mem[k] = w;
      end
      cnt = nw;
      ovf = (n > 4 * DEPTH);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle while the loader is busy; any fetch must see the NOP word.
   task automatic load_cycle(input bit v, input logic [7:0] b, input bit e);
      byte_valid_i = v;
      byte_i       = v ? b : 8'($urandom);
      load_end_i   = e;
      ce_i         = 1'($urandom_range(0, 1));
      addr_i       = $urandom;
      if (ce_i) exp_q.push_back(32'h0);
      tick();
      byte_valid_i = 1'b0;
      load_end_i   = 1'b0;
      ce_i         = 1'b0;
   endtask

   task automatic run_load(input logic [7:0] bq[$], input bit coincide);
      int cnt;
      bit ovf;
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      for (int i = 0; i < bq.size(); i++) begin
         while ($urandom_range(0, 3) == 0) load_cycle(1'b0, 8'h00, 1'b0);
         load_cycle(1'b1, bq[i], coincide && (i == bq.size() - 1));
      end
      if (!(coincide && bq.size() > 0)) load_cycle(1'b0, 8'h00, 1'b1);
      model_stream(bq, 1'b1, cnt, ovf);
      done_cnt_q.push_back(32'(cnt));
      done_ovf_q.push_back(ovf);
   endtask

   // Start and stream bytes with no end; the caller interrupts with a restart or reset.
   task automatic partial_stream(input logic [7:0] bq[$]);
      int cnt;
      bit ovf;
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      foreach (bq[i]) load_cycle(1'b1, bq[i], 1'b0);
      model_stream(bq, 1'b0, cnt, ovf);
   endtask

   task automatic read_at(input logic [31:0] a, input bit ce, input logic [31:0] e);
      ce_i   = ce;
      addr_i = a;
      if (ce) begin
         exp_q.push_back(e);
      end else begin
         @(negedge clk);
         chk("read_ce_off", inst_o, 32'h0);
      end
      tick();
      ce_i = 1'b0;
   endtask

   task automatic read_model(input logic [31:0] a);
      read_at(a, 1'b1, model_mem[a[ML+1:2]]);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a fetch result or a done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (ce_i) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL read_unexpected: got %h expected no read at %0t", inst_o, $time);
            end else begin
               chk("read_data", inst_o, exp_q.pop_front());
            end
         end
         if (load_done_o) begin
            chk("done_single_cycle", {31'b0, prev_done}, 32'h0);
            chk("done_busy", {31'b0, load_busy_o}, 32'h0);
            if (done_cnt_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL done_unexpected: got done pulse expected none at %0t", $time);
            end else begin
               chk("done_count", 32'(word_count_o), done_cnt_q.pop_front());
               chk("done_ovf", {31'b0, load_ovf_o}, {31'b0, done_ovf_q.pop_front()});
            end
         end
      end
      prev_done = load_done_o;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish by %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bq[$];
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", {31'b0, load_busy_o}, 32'h0);
      chk("rst_done", {31'b0, load_done_o}, 32'h0);
      chk("rst_ovf", {31'b0, load_ovf_o}, 32'h0);
      chk("rst_count", 32'(word_count_o), 32'h0);
      read_at(32'h0, 1'b0, 32'h0);

      // Overfill: 40 bytes into 8 words.
      bq = {};
      for (int i = 0; i < 40; i++) bq.push_back(8'(i * 7 + 1));
      run_load(bq, 1'b0);
      tick();
      chk("ovf_sticky", {31'b0, load_ovf_o}, 32'h1);
      read_at(32'h0, 1'b1, 32'h01080F16);
      for (int i = 0; i < DEPTH; i++) read_model(32'(i * 4));

      run_load({8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20}, 1'b0);
      tick();
      chk("count_holds", 32'(word_count_o), 32'd2);
      read_at(32'h0, 1'b1, 32'h34011100);
      read_at(32'h4, 1'b1, 32'h34020020);

      run_load({8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}, 1'b1);
      read_at(32'h4, 1'b1, 32'hEE000000);
      read_at(32'h0, 1'b1, 32'hAABBCCDD);

      partial_stream({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
      run_load({8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
      read_at(32'h0, 1'b1, 32'h11223344);

      read_at(32'h1, 1'b1, 32'h11223344);
      read_at(32'h3, 1'b0, 32'h0);
      read_at(32'hFFFF_FFE2, 1'b1, 32'h11223344);

      // Reset in the middle of a load.
      partial_stream({8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hE1});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", {31'b0, load_busy_o}, 32'h0);
      chk("midrst_count", 32'(word_count_o), 32'h0);
      byte_valid_i = 1'b1;
      byte_i       = 8'h55;
      load_end_i   = 1'b1;
      tick();
      byte_valid_i = 1'b0;
      load_end_i   = 1'b0;
      tick();
      chk("idle_byte_busy", {31'b0, load_busy_o}, 32'h0);
      chk("idle_byte_done", {31'b0, load_done_o}, 32'h0);
      chk("idle_byte_count", 32'(word_count_o), 32'h0);
      read_at(32'h0, 1'b1, 32'hC0C1C2C3);
      read_at(32'h4, 1'b1, 32'hD0D1D2D3);
      read_model(32'h8);

      for (int it = 0; it < 25; it++) begin
         int len;
         len = $urandom_range(0, 40);
         bq  = {};
         for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
         run_load(bq, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) != 0) begin
            for (int r = 0; r < 4; r++) begin
               if ($urandom_range(0, 4) == 0) read_at($urandom, 1'b0, 32'h0);
               else read_model($urandom);
            end
         end
      end

      repeat (4) tick();
      chk("reads_drained", 32'(exp_q.size()), 32'h0);
      chk("dones_drained", 32'(done_cnt_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
